// File: rtl/aurora_hls_monitor_pkg.sv
// Shared definitions for the Aurora HLS link-health monitor register reader:
// register offsets, AXI response codes, CTRL bit positions and state types.
package aurora_hls_monitor_pkg;

    localparam logic [5:0] REG_CTRL        = 6'h00;
    localparam logic [5:0] REG_STATUS      = 6'h04;
    localparam logic [5:0] REG_NOT_OK      = 6'h08;
    localparam logic [5:0] REG_RX_OVF      = 6'h0C;
    localparam logic [5:0] REG_TX_OVF      = 6'h10;
    localparam logic [5:0] REG_SEQ         = 6'h14;
    localparam logic [5:0] REG_LIVE_NOT_OK = 6'h18;
    localparam logic [5:0] REG_LIVE_RX_OVF = 6'h1C;
    localparam logic [5:0] REG_LIVE_TX_OVF = 6'h20;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_SNAPSHOT_BIT = 0;
    localparam int CTRL_CLEAR_BIT    = 1;

    localparam logic [12:0] CORE_STATUS_OK_DEFAULT = 13'h11ff;

    typedef enum logic { R_IDLE, R_DATA } rd_state_t;
    typedef enum logic { W_IDLE, W_RESP } wr_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_result_t;

endpackage

// File: rtl/aurora_hls_monitor_reader.sv
// AXI4-Lite register front end for the Aurora link-health monitor: coherent
// counter snapshots, clear pulse and live status. Optional macro
// AURORA_HLS_MONITOR_LIVE_READ_EN exposes live counters at 0x18/0x1C/0x20.
module aurora_hls_monitor_reader
    import aurora_hls_monitor_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 6,
    parameter logic [12:0] CORE_STATUS_OK = CORE_STATUS_OK_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [12:0]           aurora_status,
    input  logic [31:0]           core_status_not_ok_count,
    input  logic [31:0]           fifo_rx_overflow_count,
    input  logic [31:0]           fifo_tx_overflow_count,
    output logic                  monitor_clear,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    rd_state_t   r_state;
    wr_state_t   w_state;
    logic        w_ready_en;
    logic [31:0] snap_not_ok;
    logic [31:0] snap_rx_ovf;
    logic [31:0] snap_tx_ovf;
    logic [31:0] snap_seq;
    rd_result_t  rd_next;

    logic [5:0] rd_offset;
    logic [5:0] wr_offset;
    logic       wr_fire;
    logic       ctrl_hit;
    logic       ctrl_act;

    // Only word-aligned bits [5:2] take part in decode; everything else is ignored.
    logic unused_bits;
    assign unused_bits = ^{s_axi_awaddr, s_axi_araddr, s_axi_wdata[31:2], s_axi_wstrb[3:1]};

    assign rd_offset = {s_axi_araddr[5:2], 2'b00};
    assign wr_offset = {s_axi_awaddr[5:2], 2'b00};

    // AW and W are accepted together, so ready depends on both valids this cycle.
    assign wr_fire       = (w_state == W_IDLE) && w_ready_en && s_axi_awvalid && s_axi_wvalid;
    assign s_axi_awready = wr_fire;
    assign s_axi_wready  = wr_fire;
    assign ctrl_hit      = (wr_offset == REG_CTRL);
    assign ctrl_act      = wr_fire && ctrl_hit && s_axi_wstrb[0];

    // NOTE: every field gets a default before the case so no latch is inferred.
    always_comb begin
        rd_next = '{data: 32'd0, resp: RESP_SLVERR};
        case (rd_offset)
            REG_CTRL:   rd_next.resp = RESP_OKAY;
            REG_STATUS: rd_next = '{data: {15'd0, (aurora_status == CORE_STATUS_OK), 3'd0, aurora_status},
                                    resp: RESP_OKAY};
            REG_NOT_OK: rd_next = '{data: snap_not_ok, resp: RESP_OKAY};
            REG_RX_OVF: rd_next = '{data: snap_rx_ovf, resp: RESP_OKAY};
            REG_TX_OVF: rd_next = '{data: snap_tx_ovf, resp: RESP_OKAY};
            REG_SEQ:    rd_next = '{data: snap_seq,    resp: RESP_OKAY};
`ifdef AURORA_HLS_MONITOR_LIVE_READ_EN
            REG_LIVE_NOT_OK: rd_next = '{data: core_status_not_ok_count, resp: RESP_OKAY};
            REG_LIVE_RX_OVF: rd_next = '{data: fifo_rx_overflow_count,   resp: RESP_OKAY};
            REG_LIVE_TX_OVF: rd_next = '{data: fifo_tx_overflow_count,   resp: RESP_OKAY};
`endif
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= 32'd0;
            s_axi_rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s_axi_arready && s_axi_arvalid) begin
                        s_axi_rdata   <= rd_next.data;
                        s_axi_rresp   <= rd_next.resp;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_arready <= 1'b0;
                        r_state       <= R_DATA;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state      <= W_IDLE;
            w_ready_en   <= 1'b0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
        end else begin
            w_ready_en <= 1'b1;
            case (w_state)
                W_IDLE: begin
                    if (wr_fire) begin
                        s_axi_bvalid <= 1'b1;
                        s_axi_bresp  <= ctrl_hit ? RESP_OKAY : RESP_SLVERR;
                        w_state      <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid <= 1'b0;
                        w_state      <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Snapshot samples pre-clear counts; the clear pulse lands one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_not_ok   <= 32'd0;
            snap_rx_ovf   <= 32'd0;
            snap_tx_ovf   <= 32'd0;
            snap_seq      <= 32'd0;
            monitor_clear <= 1'b0;
        end else begin
            monitor_clear <= ctrl_act && s_axi_wdata[CTRL_CLEAR_BIT];
            if (ctrl_act && s_axi_wdata[CTRL_SNAPSHOT_BIT]) begin
                snap_not_ok <= core_status_not_ok_count;
                snap_rx_ovf <= fifo_rx_overflow_count;
                snap_tx_ovf <= fifo_tx_overflow_count;
                snap_seq    <= snap_seq + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_aurora_hls_monitor_reader.sv
// Self-checking bench for aurora_hls_monitor_reader: directed register-map
// cases plus randomized AXI-Lite traffic against a register-level model.
module tb_aurora_hls_monitor_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [12:0] status;
    logic [31:0] cnt [3];
    logic        monitor_clear;
    logic [5:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    aurora_hls_monitor_reader dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .aurora_status            (status),
        .core_status_not_ok_count (cnt[0]),
        .fifo_rx_overflow_count   (cnt[1]),
        .fifo_tx_overflow_count   (cnt[2]),
        .monitor_clear            (monitor_clear),
        .s_axi_awaddr             (awaddr),
        .s_axi_awvalid            (awvalid),
        .s_axi_awready            (awready),
        .s_axi_wdata              (wdata),
        .s_axi_wstrb              (wstrb),
        .s_axi_wvalid             (wvalid),
        .s_axi_wready             (wready),
        .s_axi_bresp              (bresp),
        .s_axi_bvalid             (bvalid),
        .s_axi_bready             (bready),
        .s_axi_araddr             (araddr),
        .s_axi_arvalid            (arvalid),
        .s_axi_arready            (arready),
        .s_axi_rdata              (rdata),
        .s_axi_rresp              (rresp),
        .s_axi_rvalid             (rvalid),
        .s_axi_rready             (rready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Register-level model of what the host should observe.
    logic [31:0] m_snap [3];
    logic [31:0] m_seq;

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) m_snap[k] = 32'd0;
        m_seq = 32'd0;
    endfunction

    function automatic logic [33:0] model_read(input logic [5:0] addr);
        int idx;
        idx = int'(addr[5:2]);
        case (idx)
            0:       return {2'b00, 32'd0};
            1:       return {2'b00, 15'd0, (status == 13'h11ff), 3'd0, status};
            2, 3, 4: return {2'b00, m_snap[idx-2]};
            5:       return {2'b00, m_seq};
`ifdef AURORA_HLS_MONITOR_LIVE_READ_EN
            6, 7, 8: return {2'b00, cnt[idx-6]};
`endif
            default: return {2'b10, 32'd0};
        endcase
    endfunction

    function automatic void model_write(input logic [5:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb, output logic [1:0] resp,
                                        output logic clr);
        resp = 2'b10;
        clr  = 1'b0;
        if (addr[5:2] == 4'd0) begin
            resp = 2'b00;
            if (strb[0]) begin
                if (data[0]) begin
                    for (int k = 0; k < 3; k++) m_snap[k] = cnt[k];
                    m_seq = m_seq + 32'd1;
                end
                clr = data[1];
            end
        end
    endfunction

    task automatic do_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit got = 0;
        araddr  = addr;
        arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arready) begin got = 1; break; end
        end
        if (!got) begin
            check("ar_timeout", 64'd0, 64'd1);
            arvalid = 1'b0;
            data = '1;
            resp = '1;
            return;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("rvalid_after_ar", rvalid, 1);
        data   = rdata;
        resp   = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("rvalid_drop", rvalid, 0);
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output logic clr_now, output logic clr_next);
        bit got = 0;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awready && wready) begin got = 1; break; end
        end
        if (!got) begin
            check("aw_timeout", 64'd0, 64'd1);
            awvalid = 1'b0;
            wvalid  = 1'b0;
            resp = '1; clr_now = 1'bx; clr_next = 1'bx;
            return;
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("bvalid_after_aw", bvalid, 1);
        resp    = bresp;
        clr_now = monitor_clear;
        bready  = 1'b1;
        @(posedge clk); #1;
        bready   = 1'b0;
        clr_next = monitor_clear;
        check("bvalid_drop", bvalid, 0);
    endtask

    logic [31:0] d, d2;
    logic [1:0]  r, r2, er;
    logic        c0, c1, ec;
    logic [33:0] exp_rd;

    initial begin
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0; status = '0;
        for (int k = 0; k < 3; k++) cnt[k] = '0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_arready", arready, 0);
        check("rst_rvalid",  rvalid, 0);
        check("rst_bvalid",  bvalid, 0);
        check("rst_rdata",   rdata, 0);
        check("rst_clear",   monitor_clear, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_read(6'h08, d, r);
        check("first_rd_data", d, 0);
        check("first_rd_resp", r, 0);

        // Snapshot then counters move on; snapshot must hold
        cnt[0] = 5; cnt[1] = 7; cnt[2] = 9;
        model_write(6'h00, 32'h1, 4'hf, er, ec);
        do_write(6'h00, 32'h1, 4'hf, r, c0, c1);
        check("snap_wr_resp", r, 0);
        check("snap_no_clear", c0, 0);
        do_read(6'h08, d, r); check("snap_not_ok", d, 5);
        do_read(6'h0C, d, r); check("snap_rx", d, 7);
        do_read(6'h10, d, r); check("snap_tx", d, 9);
        do_read(6'h14, d, r); check("seq_1", d, 1);
        cnt[0] = 6; cnt[1] = 8; cnt[2] = 10;
        do_read(6'h08, d, r); check("hold_not_ok", d, 5);
        do_read(6'h0C, d, r); check("hold_rx", d, 7);
        do_read(6'h10, d, r); check("hold_tx", d, 9);

        // Snapshot + clear together
        cnt[0] = 11; cnt[1] = 0; cnt[2] = 2;
        model_write(6'h00, 32'h3, 4'hf, er, ec);
        do_write(6'h00, 32'h3, 4'hf, r, c0, c1);
        check("clr_pulse", c0, 1);
        check("clr_one_cycle", c1, 0);
        do_read(6'h08, d, r); check("snap2_not_ok", d, 11);
        do_read(6'h0C, d, r); check("snap2_rx", d, 0);
        do_read(6'h10, d, r); check("snap2_tx", d, 2);
        do_read(6'h14, d, r); check("seq_2", d, 2);

        // Status register
        status = 13'h11ff;
        do_read(6'h04, d, r); check("status_ok", d, 32'h000111ff); check("status_resp", r, 0);
        status = 13'h01ff;
        do_read(6'h04, d, r); check("status_bad", d, 32'h000001ff);

        // Error responses and RO writes
        do_read(6'h3C, d, r); check("unmapped_resp", r, 2'b10); check("unmapped_data", d, 0);
        do_write(6'h08, 32'hdeadbeef, 4'hf, r, c0, c1);
        check("ro_wr_resp", r, 2'b10);
        check("ro_wr_no_clear", c0, 0);
        do_read(6'h08, d, r); check("ro_wr_no_effect", d, 11);
        exp_rd = model_read(6'h18);
        do_read(6'h18, d, r); check("live_data", d, exp_rd[31:0]); check("live_resp", r, exp_rd[33:32]);

        // CTRL write with wstrb[0]=0: OKAY, no action
        do_write(6'h00, 32'h3, 4'he, r, c0, c1);
        check("strb0_resp", r, 0);
        check("strb0_no_clear", c0, 0);
        do_read(6'h14, d, r); check("strb0_seq", d, 2);

        // Early AW must wait for W
        awaddr = 6'h00; wdata = 32'h0; wstrb = 4'hf; awvalid = 1'b1;
        repeat (3) @(negedge clk);
        check("early_aw_wait", awready, 0);
        awvalid = 1'b0;
        @(posedge clk); #1;

        // Read and snapshot accepted on the same edge: old snapshot returned
        cnt[0] = 100; cnt[1] = 200; cnt[2] = 300;
        exp_rd = model_read(6'h08);
        model_write(6'h00, 32'h1, 4'hf, er, ec);
        fork
            do_write(6'h00, 32'h1, 4'hf, r, c0, c1);
            do_read(6'h08, d, r2);
        join
        check("same_edge_old_snap", d, exp_rd[31:0]);
        do_read(6'h08, d, r); check("same_edge_new_snap", d, 100);

        // Randomized traffic
        for (int it = 0; it < 150; it++) begin
            logic [3:0] word;
            logic [5:0] addr;
            logic [31:0] wd;
            logic [3:0] ws;
            for (int k = 0; k < 3; k++)
                if ($urandom_range(0, 2) == 0)
                    cnt[k] = ($urandom_range(0, 3) == 0) ? (32'hffffffff - 32'($urandom_range(0, 3))) : $urandom;
            status = $urandom_range(0, 1) ? 13'h11ff : 13'($urandom);
            word = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            addr = {word, 2'($urandom)};
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom;
                ws = 4'($urandom);
                model_write(addr, wd, ws, er, ec);
                do_write(addr, wd, ws, r, c0, c1);
                check("rnd_bresp", r, er);
                check("rnd_clear", c0, ec);
                check("rnd_clear_end", c1, 0);
            end else begin
                exp_rd = model_read(addr);
                do_read(addr, d, r);
                check("rnd_rdata", d, exp_rd[31:0]);
                check("rnd_rresp", r, exp_rd[33:32]);
            end
        end

        // Backpressure hold, then async reset in the middle of R_DATA
        exp_rd = model_read(6'h14);
        araddr = 6'h14; arvalid = 1'b1;
        begin
            bit got = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (arready) begin got = 1; break; end
            end
            if (!got) check("hold_ar_timeout", 64'd0, 64'd1);
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_rvalid", rvalid, 1);
            check("hold_rdata", rdata, exp_rd[31:0]);
        end
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_rvalid", rvalid, 0);
        check("rst_mid_rdata", rdata, 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_read(6'h08, d, r); check("post_rst_snap", d, 0);
        do_read(6'h14, d2, r); check("post_rst_seq", d2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
